// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module : pipeline_pkg
// Shared constants, FSM state and next-PC select encodings for the PC unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [31:0] c_reset_vector = 32'h0000_3000;
  localparam logic [31:0] c_exc_vector   = 32'h0000_4180;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    TRAP = 2'd3
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_EPC  = 3'd1,
    SEL_HOLD = 3'd2,
    SEL_JR   = 3'd3,
    SEL_J    = 3'd4,
    SEL_BR   = 3'd5,
    SEL_SEQ  = 3'd6
  } npc_sel_e;

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// ============================================================================
// Module : npc_calc
// Combinational branch, jump and sequential target arithmetic (32-bit modulo).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_calc (
  input  logic [31:0] pc,
  input  logic [31:0] id_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] index,
  output logic [31:0] seq_target,
  output logic [31:0] br_target,
  output logic [31:0] j_target
);

  logic [31:0] w_id_pc_plus4;
  logic [31:0] w_br_offset;

  assign w_id_pc_plus4 = id_pc + 32'd4;
  assign w_br_offset   = {{14{imm16[15]}}, imm16, 2'b00};

  assign seq_target = pc + 32'd4;
  assign br_target  = w_id_pc_plus4 + w_br_offset;
  // Jump region comes from the delay-slot address, not the jump itself.
  assign j_target   = {w_id_pc_plus4[31:28], index, 2'b00};

endmodule

`default_nettype wire

// File: rtl/pc_next_unit.sv
// ============================================================================
// Module : pc_next_unit
// Architectural PC register, next-PC selection, boot hold-off and trap entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_next_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = c_reset_vector,
  parameter logic [31:0] EXC_VECTOR   = c_exc_vector,
  parameter int          BOOT_CYCLES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        id_branch_i,
  input  logic        id_cmp_result_i,
  input  logic [31:0] id_pc_i,
  input  logic [15:0] id_imm16_i,
  input  logic        id_j_i,
  input  logic [25:0] id_index_i,
  input  logic        id_jr_i,
  input  logic [31:0] id_jr_target_i,
  input  logic        exc_req_i,
  input  logic [31:0] exc_epc_i,
  input  logic        eret_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        ifid_flush_o,
  output logic [15:0] br_taken_cnt_o
);

  localparam int            c_bcw       = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [c_bcw-1:0] c_boot_last = c_bcw'(BOOT_CYCLES - 1);

  pc_state_e        r_state;
  logic [c_bcw-1:0] r_boot_cnt;
  logic [31:0]      r_pc;
  logic             r_pc_valid;
  logic [15:0]      r_br_cnt;

  npc_sel_e    w_sel;
  logic [31:0] w_npc;
  logic [31:0] w_seq_target;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic        w_redirect;
  logic        w_trap_entry;

  npc_calc u_npc_calc (
    .pc         (r_pc),
    .id_pc      (id_pc_i),
    .imm16      (id_imm16_i),
    .index      (id_index_i),
    .seq_target (w_seq_target),
    .br_target  (w_br_target),
    .j_target   (w_j_target)
  );

  // Only RUN and HOLD consult the inputs; BOOT and TRAP simply hold the PC.
  always_comb begin
    w_sel = SEL_HOLD;
    if ((r_state == RUN) || (r_state == HOLD)) begin
      if (exc_req_i)                          w_sel = SEL_EXC;
      else if (eret_i)                        w_sel = SEL_EPC;
      else if (stall_i)                       w_sel = SEL_HOLD;
      else if (id_jr_i)                       w_sel = SEL_JR;
      else if (id_j_i)                        w_sel = SEL_J;
      else if (id_branch_i && id_cmp_result_i) w_sel = SEL_BR;
      else                                    w_sel = SEL_SEQ;
    end
  end

  always_comb begin
    w_npc = r_pc;
    case (w_sel)
      SEL_EXC: w_npc = EXC_VECTOR;
      SEL_EPC: w_npc = exc_epc_i;
      SEL_JR:  w_npc = id_jr_target_i;
      SEL_J:   w_npc = w_j_target;
      SEL_BR:  w_npc = w_br_target;
      SEL_SEQ: w_npc = w_seq_target;
      default: w_npc = r_pc;
    endcase
  end

  assign w_redirect   = (w_sel == SEL_JR) || (w_sel == SEL_J) || (w_sel == SEL_BR);
  assign w_trap_entry = (w_sel == SEL_EXC) || (w_sel == SEL_EPC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_boot_cnt <= '0;
      r_pc       <= RESET_VECTOR;
      r_pc_valid <= 1'b0;
      r_br_cnt   <= 16'd0;
    end else begin
      case (r_state)
        BOOT: begin
          r_boot_cnt <= r_boot_cnt + 1'b1;
          if (r_boot_cnt == c_boot_last) begin
            r_state    <= RUN;
            r_pc_valid <= 1'b1;
          end
        end
        RUN, HOLD: begin
          r_pc <= w_npc;
          if (w_redirect && (r_br_cnt != 16'hFFFF)) r_br_cnt <= r_br_cnt + 16'd1;
          if (w_trap_entry) begin
            r_state    <= TRAP;
            r_pc_valid <= 1'b0;
          end else if (w_sel == SEL_HOLD) begin
            r_state <= HOLD;
          end else begin
            r_state <= RUN;
          end
        end
        TRAP: begin
          r_state    <= RUN;
          r_pc_valid <= 1'b1;
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign pc_o           = r_pc;
  assign pc_valid_o     = r_pc_valid;
  assign ifid_flush_o   = w_trap_entry;
  assign br_taken_cnt_o = r_br_cnt;

endmodule

`default_nettype wire
